// File: rtl/fruit_pkg.sv
// fruit_pkg: shared constants and the per-slot state record for the fruit
// spawner. The optional spawn-jitter build (FRUIT_SPAWN_JITTER_EN) needs no
// package-level changes.
package fruit_pkg;

  localparam int SCREEN_H = 480;
  localparam int SCREEN_W = 640;
  localparam int X_W      = $clog2(SCREEN_W);  // 10 bits
  localparam int Y_W      = 11;
  localparam int VY_W     = 7;

  typedef struct packed {
    logic                   valid;
    logic [X_W-1:0]         x;
    logic signed [Y_W-1:0]  y;
    logic signed [VY_W-1:0] vy;
  } fruit_slot_t;

endpackage

// File: rtl/fruit_slot.sv
// fruit_slot: register set of one fruit plus its ballistic motion, retire
// and slice logic.
//   clock, reset      system clock, asynchronous active-high reset
//   frame_tick_i      one-clock frame pulse; motion only happens here
//   load_i            spawn into this slot (only asserted when it is free)
//   load_x_i          launch x position
//   load_vy_i         launch vertical velocity (negative = upward)
//   slice_hit_i       slice request; honoured in any cycle while valid
//   slot_o            registered slot state
//   miss_o, slice_o   combinational events for the edge about to happen
module fruit_slot
  import fruit_pkg::*;
#(
  parameter int BASE_Y  = 480,
  parameter int GRAVITY = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   frame_tick_i,
  input  logic                   load_i,
  input  logic [X_W-1:0]         load_x_i,
  input  logic signed [VY_W-1:0] load_vy_i,
  input  logic                   slice_hit_i,
  output fruit_slot_t            slot_o,
  output logic                   miss_o,
  output logic                   slice_o
);

  localparam logic signed [Y_W-1:0]  Y_BASE = Y_W'(BASE_Y);
  localparam logic signed [VY_W-1:0] VY_G   = VY_W'(GRAVITY);

  fruit_slot_t            slot_q, slot_d;
  logic signed [Y_W-1:0]  y_new;
  logic signed [VY_W-1:0] vy_new;
  logic                   falling;

  always_comb begin
    y_new   = slot_q.y + {{(Y_W-VY_W){slot_q.vy[VY_W-1]}}, slot_q.vy};
    vy_new  = slot_q.vy + VY_G;
    falling = !vy_new[VY_W-1] && (vy_new != '0);
  end

  always_comb begin
    slot_d  = slot_q;
    miss_o  = 1'b0;
    slice_o = 1'b0;
    if (slot_q.valid) begin
      // Slice takes priority over motion, so a fruit sliced on its retire
      // frame counts as sliced, never as missed.
      if (slice_hit_i) begin
        slot_d.valid = 1'b0;
        slice_o      = 1'b1;
      end else if (frame_tick_i) begin
        slot_d.y  = y_new;
        slot_d.vy = vy_new;
        if (falling && (y_new >= Y_BASE)) begin
          slot_d.valid = 1'b0;
          miss_o       = 1'b1;
        end
      end
    end else if (load_i) begin
      slot_d.valid = 1'b1;
      slot_d.x     = load_x_i;
      slot_d.y     = Y_BASE;
      slot_d.vy    = load_vy_i;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/fruit_spawner.sv
// fruit_spawner: pool of NUM_SLOTS fruits. Spawns one at a random x/velocity
// every SPAWN_PERIOD frame ticks into the lowest free slot, moves live fruits
// once per frame and retires them when sliced or back below the baseline.
//   clock, reset   system clock, asynchronous active-high reset
//   frame_tick     one-clock pulse per video frame
//   enable         spawning allowed (motion continues when low)
//   rnd[4:0]       random number, sampled only in a spawn cycle
//   slice_hit[N]   per-slot slice requests
//   fruit_valid[N] slot occupied
//   fruit_x        slot i x in [10i+9:10i], unsigned
//   fruit_y        slot i y in [11i+10:11i], signed
//   spawn_pulse, miss_pulse, slice_pulse   one-clock event pulses
// Build option: FRUIT_SPAWN_JITTER_EN reloads each spawn interval as
// SPAWN_PERIOD + rnd[3:0] (rnd taken at the wrap); undefined = fixed period.
module fruit_spawner #(
  parameter int NUM_SLOTS    = 4,
  parameter int SPAWN_PERIOD = 60,
  parameter int SCREEN_H     = fruit_pkg::SCREEN_H,
  parameter int X_SCALE      = 20,
  parameter int BASE_VY      = 12,
  parameter int GRAVITY      = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic                    enable,
  input  logic [4:0]              rnd,
  input  logic [NUM_SLOTS-1:0]    slice_hit,
  output logic [NUM_SLOTS-1:0]    fruit_valid,
  output logic [10*NUM_SLOTS-1:0] fruit_x,
  output logic [11*NUM_SLOTS-1:0] fruit_y,
  output logic                    spawn_pulse,
  output logic                    miss_pulse,
  output logic                    slice_pulse
);

  import fruit_pkg::*;

  // 9 bits covers SPAWN_PERIOD up to 255 plus up to 15 of jitter.
  localparam int CNT_W = 9;

  logic [CNT_W-1:0]       cnt_q, cnt_d, period;
  logic                   wrap, attempt, found, spawn;
  logic [NUM_SLOTS-1:0]   valid, pick, load, miss_ev, slice_ev;
  logic [X_W-1:0]         load_x;
  logic signed [VY_W-1:0] load_vy;
  logic                   spawn_q, miss_q, slice_q;
  fruit_slot_t            slot_s [NUM_SLOTS];

`ifdef FRUIT_SPAWN_JITTER_EN
  logic [CNT_W-1:0] period_q, period_d;

  always_comb begin
    period_d = period_q;
    if (attempt) period_d = CNT_W'(SPAWN_PERIOD) + CNT_W'(rnd[3:0]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) period_q <= CNT_W'(SPAWN_PERIOD);
    else       period_q <= period_d;
  end

  assign period = period_q;
`else
  assign period = CNT_W'(SPAWN_PERIOD);
`endif

  always_comb begin
    wrap    = (cnt_q == period - CNT_W'(1));
    attempt = frame_tick && wrap;
    cnt_d   = cnt_q;
    if (frame_tick) cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Freeness comes from the registered valid bits: a slot retiring on this
  // frame is still occupied, and a slot being sliced is necessarily valid.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      if (!found && !valid[i]) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  assign spawn   = attempt && enable && found;
  assign load    = pick & {NUM_SLOTS{spawn}};
  assign load_x  = X_W'(rnd) * X_W'(X_SCALE);
  assign load_vy = VY_W'(0) - (VY_W'(BASE_VY) + VY_W'(rnd[2:0]));

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    fruit_slot #(
      .BASE_Y  (SCREEN_H),
      .GRAVITY (GRAVITY)
    ) u_slot (
      .clock        (clock),
      .reset        (reset),
      .frame_tick_i (frame_tick),
      .load_i       (load[g]),
      .load_x_i     (load_x),
      .load_vy_i    (load_vy),
      .slice_hit_i  (slice_hit[g]),
      .slot_o       (slot_s[g]),
      .miss_o       (miss_ev[g]),
      .slice_o      (slice_ev[g])
    );
    assign valid[g]            = slot_s[g].valid;
    assign fruit_x[10*g +: 10] = slot_s[g].x;
    assign fruit_y[11*g +: 11] = slot_s[g].y;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      spawn_q <= 1'b0;
      miss_q  <= 1'b0;
      slice_q <= 1'b0;
    end else begin
      spawn_q <= spawn;
      miss_q  <= |miss_ev;
      slice_q <= |slice_ev;
    end
  end

  assign fruit_valid = valid;
  assign spawn_pulse = spawn_q;
  assign miss_pulse  = miss_q;
  assign slice_pulse = slice_q;

endmodule

// File: tb/tb_fruit_spawner.sv
`timescale 1ns/1ps
module tb_fruit_spawner;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [4:0]  rnd;
  logic        a_tick, b_tick;
  logic [3:0]  a_sh, b_sh;
  logic [3:0]  a_valid, b_valid;
  logic [39:0] a_x, b_x;
  logic [43:0] a_y, b_y;
  logic        a_sp, a_mi, a_sl, b_sp, b_mi, b_sl;

  always #5 clock = ~clock;

  // dut_a: default configuration. dut_b: short period so the pool can fill.
  fruit_spawner dut_a (
    .clock(clock), .reset(reset), .frame_tick(a_tick), .enable(enable),
    .rnd(rnd), .slice_hit(a_sh), .fruit_valid(a_valid), .fruit_x(a_x),
    .fruit_y(a_y), .spawn_pulse(a_sp), .miss_pulse(a_mi), .slice_pulse(a_sl)
  );

  fruit_spawner #(.SPAWN_PERIOD(6)) dut_b (
    .clock(clock), .reset(reset), .frame_tick(b_tick), .enable(enable),
    .rnd(rnd), .slice_hit(b_sh), .fruit_valid(b_valid), .fruit_x(b_x),
    .fruit_y(b_y), .spawn_pulse(b_sp), .miss_pulse(b_mi), .slice_pulse(b_sl)
  );

  typedef struct {
    int unsigned        tick;
    logic [4:0]         rnd;
    logic               en;
    logic [3:0]         valid;
    logic               spawn;
    logic               miss;
    logic               slice;
    logic               chk_pos;
    logic [9:0]         x;
    logic signed [10:0] y;
  } vec_t;

  localparam int NA = 420;
  vec_t        vecs [NA];
  vec_t        exp_q [$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int          slice_at;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic do_tick(input bit sel, input logic [3:0] sh, input vec_t v, input bit chk_clear);
    vec_t       e;
    logic [3:0] val;
    logic [2:0] pl;
    logic [9:0] x0;
    logic [10:0] y0;
    @(negedge clock);
    rnd    = v.rnd;
    enable = v.en;
    if (sel) begin b_tick = 1'b1; b_sh = sh; end
    else     begin a_tick = 1'b1; a_sh = sh; end
    exp_q.push_back(v);
    @(negedge clock);
    a_tick = 1'b0; b_tick = 1'b0; a_sh = '0; b_sh = '0;
    e   = exp_q.pop_front();
    val = sel ? b_valid : a_valid;
    pl  = sel ? {b_sp, b_mi, b_sl} : {a_sp, a_mi, a_sl};
    x0  = sel ? b_x[9:0] : a_x[9:0];
    y0  = sel ? b_y[10:0] : a_y[10:0];
    check($sformatf("%s tick%0d valid/spawn/miss/slice", sel ? "B" : "A", e.tick),
          64'({val, pl}), 64'({e.valid, e.spawn, e.miss, e.slice}));
    if (e.chk_pos)
      check($sformatf("%s tick%0d slot0 x/y", sel ? "B" : "A", e.tick),
            64'({x0, y0}), 64'({e.x, e.y}));
    if (chk_clear) begin
      @(negedge clock);
      pl = sel ? {b_sp, b_mi, b_sl} : {a_sp, a_mi, a_sl};
      check($sformatf("%s tick%0d pulses one clock", sel ? "B" : "A", e.tick), 64'(pl), 64'(0));
    end
  endtask

  // Slice outside a frame tick; slot1 is empty so its request is ignored.
  task automatic slice_seq();
    @(negedge clock); a_sh = 4'b0011;
    @(negedge clock); a_sh = 4'b0000;
    check("A slice live slot", 64'({a_valid, a_sp, a_mi, a_sl}), 64'({4'b0000, 3'b001}));
    @(negedge clock); a_sh = 4'b0010;
    @(negedge clock); a_sh = 4'b0000;
    check("A slice empty slot", 64'({a_valid, a_sp, a_mi, a_sl}), 64'(0));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int   next_att, att_no, dis_start, s_tick, vy0, k, yv, vyk;
    bit   alive, was_alive, en, is_att;
    logic [4:0] r;
    logic [9:0] x0;
    int   rnd_att [8];
    vec_t v;

    // Expected single-slot trajectory table for dut_a (fruits live <= 39
    // frames, shorter than any spawn interval, so only slot0 is ever used).
    rnd_att = '{5, 5, 31, 25, 9, 0, 0, 0};
    next_att = 60; att_no = 0; dis_start = 0; alive = 0; s_tick = 0;
    vy0 = 0; x0 = '0; yv = 0; slice_at = 0;
    for (int n = 1; n <= NA; n++) begin
      en     = !(dis_start != 0 && n >= dis_start && n < dis_start + 200);
      is_att = (n == next_att);
      r      = is_att ? 5'(rnd_att[att_no % 8]) : 5'((n * 7) % 32);
      was_alive = alive;
      v.spawn = 1'b0; v.miss = 1'b0; v.slice = 1'b0;
      if (alive) begin
        k   = n - s_tick;
        yv  = 480 + vy0 * k + (k * (k - 1)) / 2;
        vyk = vy0 + k;
        if (vyk > 0 && yv >= 480) begin v.miss = 1'b1; alive = 0; end
      end
      if (is_att) begin
        if (en && !was_alive) begin
          v.spawn = 1'b1; alive = 1; s_tick = n;
          vy0 = -(12 + int'(r[2:0]));
          x0  = 10'(int'(r) * 20);
          yv  = 480;
        end
`ifdef FRUIT_SPAWN_JITTER_EN
        next_att = n + 60 + int'(r[3:0]);
`else
        next_att = n + 60;
`endif
        att_no++;
        if (att_no == 2) slice_at = n;
        if (att_no == 3) dis_start = n + 1;
      end
      v.tick = n; v.rnd = r; v.en = en; v.valid = {3'b000, alive};
      v.chk_pos = alive || v.miss; v.x = x0; v.y = 11'(yv);
      vecs[n-1] = v;
      if (n == slice_at) alive = 0;
    end

    reset = 1'b1; enable = 1'b0; rnd = '0;
    a_tick = 1'b0; b_tick = 1'b0; a_sh = '0; b_sh = '0;
    repeat (3) @(negedge clock);
    check("A reset state", 64'({a_valid, a_sp, a_mi, a_sl}), 64'(0));
    check("A reset pos", 64'({a_x, a_y[19:0]}), 64'(0));
    check("B reset state", 64'({b_valid, b_sp, b_mi, b_sl}), 64'(0));
    reset = 1'b0;

    // dut_b: spawns at 6,12,18,24; attempt 30 dropped (pool full); slots
    // retire 25 frames after spawn; slot2 sliced on its retire frame 43.
    for (int n = 1; n <= 43; n++) begin
      v.tick = n; v.rnd = 5'd16; v.en = 1'b1;
      v.valid[0] = (n >= 6 && n < 31) || n >= 36;
      v.valid[1] = (n >= 12 && n < 37) || n >= 42;
      v.valid[2] = (n >= 18 && n < 43);
      v.valid[3] = (n >= 24);
      v.spawn   = (n % 6 == 0) && (n != 30);
      v.miss    = (n == 31) || (n == 37);
      v.slice   = (n == 43);
      v.chk_pos = (n == 6) || (n == 30) || (n == 36);
      v.x       = 10'd320;
      v.y       = (n == 30) ? 11'sd468 : 11'sd480;
      do_tick(1'b1, (n == 43) ? 4'b0100 : 4'b0000, v, n != 43);
    end

    // Asynchronous reset while three fruits are live and slice_pulse is high.
    #2 reset = 1'b1;
    #1;
    check("B async reset flags", 64'({b_valid, b_sp, b_mi, b_sl}), 64'(0));
    check("B async reset pos", 64'({b_x[9:0], b_y[10:0]}), 64'(0));
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < NA; i++) begin
      do_tick(1'b0, 4'b0000, vecs[i], 1'b1);
      if (vecs[i].tick == slice_at) slice_seq();
    end

    check("scoreboard drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
